mips_regfile_multi: RTL and testbench

//  Parametrised successor to the pipeline's GPR file.
//  - N registered read ports, one byte-enabled write port, register 0 hardwired to zero.
//  - Hardware clear sequencer zeroes every entry after reset; no X reads after power-up.
//  - Sits in the ID stage: read addresses from the IF/ID register, write port driven by WB.

---
 rtl/mips_regfile_pkg.sv | 24 ++
 rtl/mips_regfile_byte_merge.sv | 23 ++
 rtl/mips_regfile_multi.sv | 109 ++++++++++
 tb/tb_mips_regfile_multi.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_pkg.sv
// rtl/mips_regfile_pkg.sv - shared state type, byte-lane helper and configuration limits for the GPR file
package mips_regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_LANE_W   = 8;
    localparam int RF_MIN_RD   = 1;
    localparam int RF_MAX_RD   = 4;
    localparam int RF_MIN_REGS = 2;

    function automatic int rf_byte_lanes(input int data_w);
        return data_w / RF_LANE_W;
    endfunction

    function automatic bit rf_cfg_ok(input int data_w, input int num_regs, input int num_rd);
        return (data_w > 0) && (data_w % RF_LANE_W == 0)
            && (num_rd >= RF_MIN_RD) && (num_rd <= RF_MAX_RD)
            && (num_regs >= RF_MIN_REGS) && ((num_regs & (num_regs - 1)) == 0);
    endfunction

endpackage

// File: rtl/mips_regfile_byte_merge.sv
// rtl/mips_regfile_byte_merge.sv - combinational byte-lane merge of a new word over an old word
module mips_regfile_byte_merge
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   merged
);
    localparam int NB = rf_byte_lanes(DATA_W);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) begin
                merged[i*RF_LANE_W +: RF_LANE_W] = new_word[i*RF_LANE_W +: RF_LANE_W];
            end
        end
    end

endmodule

// File: rtl/mips_regfile_multi.sv
// rtl/mips_regfile_multi.sv - N-read/1-write byte-enabled GPR file with hardware clear, r0 reads zero
// Define REGFILE_BYPASS_EN to forward a same-edge write to colliding read ports.
module mips_regfile_multi
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] Rd_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]           Rd_rd_data,
    input  logic [$clog2(NUM_REGS)-1:0]        Rd_addr,
    input  logic [DATA_W-1:0]                  Rd_in,
    input  logic [DATA_W/8-1:0]                Rd_Byte_w_en,
    output logic                               ready
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    generate
        if (!rf_cfg_ok(DATA_W, NUM_REGS, NUM_RD)) begin : g_bad_cfg
            $error("mips_regfile_multi: unsupported parameter set");
        end
    endgenerate

    rf_state_t state, next_state;
    logic [AW-1:0]            clr_idx;
    logic [DATA_W-1:0]        mem [NUM_REGS];
    logic [DATA_W-1:0]        wr_merged;
    logic                     wr_fire;
    logic [NUM_RD*DATA_W-1:0] rd_next;

    assign wr_fire = (state == RF_RUN) && (Rd_addr != '0) && (|Rd_Byte_w_en);

    // One merge serves both the write path and the bypass: a collision is by definition at Rd_addr.
    mips_regfile_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (mem[Rd_addr]),
        .new_word (Rd_in),
        .byte_en  (Rd_Byte_w_en),
        .merged   (wr_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == RF_CLEAR && clr_idx == LAST_IDX) begin
            next_state = RF_RUN;
        end
    end

    // Entry 0 is never stored to; reads of address 0 are forced to zero instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= AW'(1);
            ready   <= 1'b0;
        end else begin
            ready <= (next_state == RF_RUN);
            if (state == RF_CLEAR && clr_idx != LAST_IDX) begin
                clr_idx <= clr_idx + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_fire) begin
                mem[Rd_addr] <= wr_merged;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (Rd_rd_addr[k*AW +: AW] == '0) begin
                rd_next[k*DATA_W +: DATA_W] = '0;
            end else if (BYPASS && wr_fire && Rd_rd_addr[k*AW +: AW] == Rd_addr) begin
                rd_next[k*DATA_W +: DATA_W] = wr_merged;
            end else begin
                rd_next[k*DATA_W +: DATA_W] = mem[Rd_rd_addr[k*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != RF_RUN) begin
            Rd_rd_data <= '0;
        end else begin
            Rd_rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_mips_regfile_multi.sv
// tb/tb_mips_regfile_multi.sv - scoreboard bench for mips_regfile_multi against a behavioural register model
module tb_mips_regfile_multi;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data;
    logic [AW-1:0]     w_addr = '0;
    logic [DW-1:0]     w_data = '0;
    logic [3:0]        w_en = '0;
    logic              ready;

    mips_regfile_multi #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rd_rd_addr   (rd_addr),
        .Rd_rd_data   (rd_data),
        .Rd_addr      (w_addr),
        .Rd_in        (w_data),
        .Rd_Byte_w_en (w_en),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                stamp;
        logic [NRD*DW-1:0] data;
        logic              rdy;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            since_rst = 0;
    logic [DW-1:0] model [NR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: reset wipes every register; the file is usable once NR-1 clear edges have passed.
    task automatic apply(input logic r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] we);
        exp_t          e;
        logic [DW-1:0] mg;
        logic [AW-1:0] a;
        rst = r; rd_addr = {a1, a0}; w_addr = wa; w_data = wd; w_en = we;
        e.stamp = cyc + 1;
        e.data  = '0;
        if (r) begin
            since_rst = 0;
            e.rdy = 1'b0;
            foreach (model[i]) model[i] = '0;
        end else if (since_rst < NR - 1) begin
            since_rst++;
            e.rdy = (since_rst >= NR - 1);
        end else begin
            mg = model[wa];
            for (int i = 0; i < 4; i++) if (we[i]) mg[8*i +: 8] = wd[8*i +: 8];
            for (int k = 0; k < NRD; k++) begin
                a = (k == 0) ? a0 : a1;
                if (a == 0) e.data[k*DW +: DW] = '0;
                else if (BYP && a == wa && we != 0) e.data[k*DW +: DW] = mg;
                else e.data[k*DW +: DW] = model[a];
            end
            if (wa != 0) model[wa] = mg;
            e.rdy = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            apply(1'b0, AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
                  AW'($urandom_range(0, NR - 1)), $urandom, 4'($urandom_range(0, 15)));
            n++;
            if (ready) break;
        end
        check(name, 64'(n), 64'(NR - 1));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].stamp <= cyc) begin
                mon = sb.pop_front();
                if (mon.stamp != cyc) check("sb_stamp", 64'(cyc), 64'(mon.stamp));
                check("sb_rd_data", rd_data, mon.data);
                check("sb_ready", 64'(ready), 64'(mon.rdy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        apply(1'b1, 0, 0, 0, 0, 0);
        check("reset_ready", 64'(ready), 0);
        check("reset_rd_data", rd_data, 0);
        wait_clear("clear_latency");
        for (int a = 0; a < NR; a++) begin
            apply(1'b0, AW'(a), AW'(NR - 1 - a), 0, 0, 0);
        end
        check("post_clear_read", rd_data, 0);

        apply(1'b0, 0, 0, 5, 32'hDEADBEEF, 4'hF);
        apply(1'b0, 5, 0, 0, 0, 0);
        check("r5_full_write", 64'(rd_data[31:0]), 64'h0DEADBEEF);
        apply(1'b0, 0, 0, 5, 32'h11223344, 4'b0101);
        apply(1'b0, 5, 5, 0, 0, 0);
        check("r5_byte_write", 64'(rd_data[31:0]), 64'h0DE22BE44);
        apply(1'b0, 0, 0, 0, 32'hFFFFFFFF, 4'hF);
        apply(1'b0, 0, 0, 0, 0, 0);
        check("r0_port0", 64'(rd_data[31:0]), 0);
        check("r0_port1", 64'(rd_data[63:32]), 0);
        apply(1'b0, 7, 0, 7, 32'hA5A5A5A5, 4'hF);
        check("r7_collision", 64'(rd_data[31:0]), BYP ? 64'h0A5A5A5A5 : 64'h0);
        apply(1'b0, 7, 7, 0, 0, 0);
        check("r7_after", 64'(rd_data[31:0]), 64'h0A5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            apply(1'b0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end

        apply(1'b1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply(1'b0, 5, 7, 9, 32'h12345678, 4'hF);
        apply(1'b1, 0, 0, 0, 0, 0);
        check("midclear_ready", 64'(ready), 0);
        wait_clear("reclear_latency");
        apply(1'b0, 5, 7, 0, 0, 0);
        check("midclear_data", rd_data, 0);
        apply(1'b0, 0, 0, 9, 32'hCAFEF00D, 4'hF);
        apply(1'b0, 9, 0, 0, 0, 0);
        check("r9_write", 64'(rd_data[31:0]), 64'h0CAFEF00D);
        apply(1'b1, 0, 0, 0, 0, 0);
        check("run_rst_ready", 64'(ready), 0);
        wait_clear("run_reclear_latency");
        apply(1'b0, 9, 9, 0, 0, 0);
        check("r9_cleared", rd_data, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
